// File: rtl/opposite_number_arbiter.sv
// Round-robin arbiter sharing one two's-complement negation unit across requesters.
// Define OPPOSITE_NUMBER_SAT_EN to saturate -2^(WIDTH-1) to 2^(WIDTH-1)-1 instead of wrapping.
module opposite_number_arbiter #(
   parameter  int WIDTH = 8,
   parameter  int NREQ  = 4,
   localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [IDW-1:0]        out_id,
   output logic                  out_ovf,
   output logic [7:0]            ovf_cnt
);

   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MAX = ~MIN;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   gnt_idx;
   logic [IDW-1:0]   idx;
   logic             any;
   logic             free;
   logic             xfer;
   logic             accept;
   logic [WIDTH-1:0] operand;
   logic [WIDTH-1:0] neg_raw;
   logic [WIDTH-1:0] result;
   logic             is_min;

   // First valid requester at or after rr_ptr; wrap relies on NREQ being a power of 2.
   always_comb begin
      any     = 1'b0;
      gnt_idx = '0;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = rr_ptr + IDW'(k);
         if (!any && req_valid[idx]) begin
            any     = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   assign free      = (state == EMPTY) || out_ready;
   assign req_ready = (free && any && !rst) ? (NREQ'(1) << gnt_idx) : '0;
   assign xfer      = |req_ready;
   assign accept    = out_valid && out_ready;

   assign operand = req_data[int'(gnt_idx)*WIDTH +: WIDTH];
   assign neg_raw = ~operand + ONE;
   assign is_min  = (operand == MIN);

`ifdef OPPOSITE_NUMBER_SAT_EN
   assign result = is_min ? MAX : neg_raw;
`else
   assign result = neg_raw;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
         out_ovf   <= 1'b0;
         ovf_cnt   <= '0;
         rr_ptr    <= '0;
      end else begin
         if (xfer) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_data  <= result;
            out_id    <= gnt_idx;
            out_ovf   <= is_min;
            rr_ptr    <= gnt_idx + IDW'(1);
         end else if (accept) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
         end
         if (accept && out_ovf && (ovf_cnt != 8'hFF))
            ovf_cnt <= ovf_cnt + 8'd1;
      end
   end

endmodule
